// File: rtl/axi_vga_pkg.sv
// Shared types and defaults for the VGA frame fetch controller.
// Holds the controller state encoding and restart-gap default.
package axi_vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_GAP
    } vga_state_e;

    localparam int unsigned RestartGapDef = 2;

endpackage

// File: rtl/axi_vga_burst_cnt.sv
// Outstanding AXI read-burst counter snooped from AR/R handshakes.
// Saturates at all-ones and never wraps below zero.
module axi_vga_burst_cnt #(
    parameter int unsigned CntWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                zero_o
);

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i && cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/axi_vga_frame_ctrl.sv
// Frame fetch controller: gates the scan-out fetcher and flips the
// double buffer at vsync once all in-flight bursts have returned.
module axi_vga_frame_ctrl
    import axi_vga_pkg::*;
#(
    parameter int unsigned CntWidth   = 4,
    parameter int unsigned RestartGap = RestartGapDef
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [63:0] fb0_addr_i,
    input  logic [63:0] fb1_addr_i,
    input  logic [31:0] frame_size_i,
    input  logic [7:0]  burst_len_i,
    input  logic        swap_req_i,
    input  logic        vsync_i,
    input  logic        ar_valid_i,
    input  logic        ar_ready_i,
    input  logic        r_valid_i,
    input  logic        r_ready_i,
    input  logic        r_last_i,
    output logic        fetch_enable_o,
    output logic [63:0] start_addr_o,
    output logic [31:0] frame_size_o,
    output logic [7:0]  burst_len_o,
    output logic        active_buf_o,
    output logic        swap_pending_o,
    output logic        swap_done_o,
    output logic        busy_o
);

    localparam int unsigned GapW =
        (RestartGap > 1) ? $clog2(RestartGap) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(RestartGap - 1);

    vga_state_e state_q, state_d;

    logic [GapW-1:0] gap_q;
    logic            active_q;
    logic            pending_q;
    logic            done_q;
    logic [63:0]     addr_q;
    logic [31:0]     size_q;
    logic [7:0]      blen_q;

    logic [CntWidth-1:0] cnt;
    logic                cnt_zero;
    logic                swap_any;
    logic                gap_entry;
    logic                buf_d;

    axi_vga_burst_cnt #(
        .CntWidth (CntWidth)
    ) u_burst_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ar_valid_i & ar_ready_i),
        .dec_i  (r_valid_i & r_ready_i & r_last_i),
        .cnt_o  (cnt),
        .zero_o (cnt_zero)
    );

    assign swap_any = pending_q | swap_req_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_GAP;
            end
            ST_RUN: begin
                if (!enable_i || (vsync_i && swap_any))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_zero)
                    state_d = enable_i ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_q == GapLast)
                    state_d = enable_i ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A swap is only ever applied on the cycle that enters GAP.
    assign gap_entry = (state_d == ST_GAP) && (state_q != ST_GAP);
    assign buf_d     = active_q ^ (gap_entry & swap_any);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            blen_q    <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= (state_q == ST_GAP) ? gap_q + GapW'(1) : '0;
            active_q  <= buf_d;
            pending_q <= gap_entry ? 1'b0 : swap_any;
            done_q    <= gap_entry & swap_any;
            if (state_q == ST_IDLE || gap_entry) begin
                addr_q <= buf_d ? fb1_addr_i : fb0_addr_i;
                size_q <= frame_size_i;
                blen_q <= burst_len_i;
            end
        end
    end

    assign fetch_enable_o = (state_q == ST_RUN);
    assign start_addr_o   = addr_q;
    assign frame_size_o   = size_q;
    assign burst_len_o    = blen_q;
    assign active_buf_o   = active_q;
    assign swap_pending_o = pending_q;
    assign swap_done_o    = done_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_vga_frame_ctrl.sv
// Directed bench for the VGA frame fetch controller.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_axi_vga_frame_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic [63:0] fb0_addr_i = 64'h8000_0000;
    logic [63:0] fb1_addr_i = 64'h9000_0000;
    logic [31:0] frame_size_i = 32'h1000;
    logic [7:0]  burst_len_i = 8'h0f;
    logic        swap_req_i = 1'b0;
    logic        vsync_i = 1'b0;
    logic        ar_valid_i = 1'b0;
    logic        ar_ready_i = 1'b0;
    logic        r_valid_i = 1'b0;
    logic        r_ready_i = 1'b0;
    logic        r_last_i = 1'b0;
    logic        fetch_enable_o;
    logic [63:0] start_addr_o;
    logic [31:0] frame_size_o;
    logic [7:0]  burst_len_o;
    logic        active_buf_o;
    logic        swap_pending_o;
    logic        swap_done_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;
    int n_done;

    axi_vga_frame_ctrl dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .fb0_addr_i     (fb0_addr_i),
        .fb1_addr_i     (fb1_addr_i),
        .frame_size_i   (frame_size_i),
        .burst_len_i    (burst_len_i),
        .swap_req_i     (swap_req_i),
        .vsync_i        (vsync_i),
        .ar_valid_i     (ar_valid_i),
        .ar_ready_i     (ar_ready_i),
        .r_valid_i      (r_valid_i),
        .r_ready_i      (r_ready_i),
        .r_last_i       (r_last_i),
        .fetch_enable_o (fetch_enable_o),
        .start_addr_o   (start_addr_o),
        .frame_size_o   (frame_size_o),
        .burst_len_o    (burst_len_o),
        .active_buf_o   (active_buf_o),
        .swap_pending_o (swap_pending_o),
        .swap_done_o    (swap_done_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ar_set(input logic v);
        ar_valid_i = v;
        ar_ready_i = v;
    endtask

    task automatic rl_set(input logic v);
        r_valid_i = v;
        r_ready_i = v;
        r_last_i  = v;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_fetch", 64'(fetch_enable_o), 64'd0);
        chk("rst_active", 64'(active_buf_o), 64'd0);
        chk("rst_pending", 64'(swap_pending_o), 64'd0);
        chk("rst_done", 64'(swap_done_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_addr", start_addr_o, 64'd0);
        rst_ni = 1'b1;
        tick();
        chk("idle_addr", start_addr_o, 64'h8000_0000);
        chk("idle_size", 64'(frame_size_o), 64'h1000);
        chk("idle_blen", 64'(burst_len_o), 64'h0f);

        // enable: fetch after 1+RestartGap cycles
        enable_i = 1'b1;
        tick();
        chk("gap0_busy", 64'(busy_o), 64'd1);
        chk("gap0_fetch", 64'(fetch_enable_o), 64'd0);
        tick();
        chk("gap1_fetch", 64'(fetch_enable_o), 64'd0);
        tick();
        chk("run_fetch", 64'(fetch_enable_o), 64'd1);
        chk("run_addr", start_addr_o, 64'h8000_0000);

        // counter corner cases
        ar_set(1'b1);
        tick();
        ar_set(1'b0);
        chk("cnt_inc", 64'(dut.u_burst_cnt.cnt_o), 64'd1);
        ar_set(1'b1);
        rl_set(1'b1);
        tick();
        ar_set(1'b0);
        chk("cnt_both", 64'(dut.u_burst_cnt.cnt_o), 64'd1);
        tick();
        chk("cnt_dec", 64'(dut.u_burst_cnt.cnt_o), 64'd0);
        tick();
        rl_set(1'b0);
        chk("cnt_floor", 64'(dut.u_burst_cnt.cnt_o), 64'd0);

        // vsync without pending swap stays in RUN
        vsync_i = 1'b1;
        tick();
        vsync_i = 1'b0;
        chk("vsync_nop", 64'(fetch_enable_o), 64'd1);

        // swap with two bursts in flight
        ar_set(1'b1);
        tick();
        tick();
        ar_set(1'b0);
        chk("cnt_two", 64'(dut.u_burst_cnt.cnt_o), 64'd2);
        swap_req_i = 1'b1;
        tick();
        swap_req_i = 1'b0;
        chk("sw_pend", 64'(swap_pending_o), 64'd1);
        chk("sw_run", 64'(fetch_enable_o), 64'd1);
        vsync_i = 1'b1;
        tick();
        vsync_i = 1'b0;
        chk("drain_fetch", 64'(fetch_enable_o), 64'd0);
        chk("drain_busy", 64'(busy_o), 64'd1);
        tick();
        tick();
        chk("drain_hold", 64'(fetch_enable_o), 64'd0);
        rl_set(1'b1);
        tick();
        chk("drain_cnt1", 64'(dut.u_burst_cnt.cnt_o), 64'd1);
        tick();
        rl_set(1'b0);
        chk("drain_cnt0", 64'(dut.u_burst_cnt.cnt_o), 64'd0);
        chk("drain_nodone", 64'(swap_done_o), 64'd0);
        chk("drain_act", 64'(active_buf_o), 64'd0);
        tick();
        chk("flip_act", 64'(active_buf_o), 64'd1);
        chk("flip_done", 64'(swap_done_o), 64'd1);
        chk("flip_pend", 64'(swap_pending_o), 64'd0);
        chk("flip_addr", start_addr_o, 64'h9000_0000);
        tick();
        chk("flip_done_off", 64'(swap_done_o), 64'd0);
        chk("flip_gap", 64'(fetch_enable_o), 64'd0);
        tick();
        chk("flip_run", 64'(fetch_enable_o), 64'd1);

        // config holds while running
        fb1_addr_i = 64'hA000_0000;
        frame_size_i = 32'h2000;
        tick();
        chk("hold_addr", start_addr_o, 64'h9000_0000);
        chk("hold_size", 64'(frame_size_o), 64'h1000);
        fb1_addr_i = 64'h9000_0000;
        frame_size_i = 32'h1000;

        // three requests coalesce into one flip
        for (int i = 0; i < 3; i++) begin
            swap_req_i = 1'b1;
            tick();
            swap_req_i = 1'b0;
            tick();
        end
        chk("coal_pend", 64'(swap_pending_o), 64'd1);
        vsync_i = 1'b1;
        tick();
        vsync_i = 1'b0;
        chk("coal_drain", 64'(fetch_enable_o), 64'd0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (swap_done_o) n_done++;
        end
        chk("coal_ndone", 64'(n_done), 64'd1);
        chk("coal_act", 64'(active_buf_o), 64'd0);
        chk("coal_run", 64'(fetch_enable_o), 64'd1);
        chk("coal_addr", start_addr_o, 64'h8000_0000);

        // disable with one burst in flight
        ar_set(1'b1);
        tick();
        ar_set(1'b0);
        enable_i = 1'b0;
        tick();
        chk("dis_fetch", 64'(fetch_enable_o), 64'd0);
        chk("dis_busy", 64'(busy_o), 64'd1);
        enable_i = 1'b1;
        tick();
        chk("dis_tog", 64'(busy_o), 64'd1);
        chk("dis_tog_f", 64'(fetch_enable_o), 64'd0);
        tick();
        chk("dis_wait", 64'(busy_o), 64'd1);
        enable_i = 1'b0;
        rl_set(1'b1);
        tick();
        rl_set(1'b0);
        chk("dis_last", 64'(busy_o), 64'd1);
        tick();
        chk("dis_idle", 64'(busy_o), 64'd0);
        chk("dis_idle_f", 64'(fetch_enable_o), 64'd0);

        // swap requested in IDLE is applied on IDLE->GAP
        swap_req_i = 1'b1;
        tick();
        swap_req_i = 1'b0;
        tick();
        tick();
        chk("ip_pend", 64'(swap_pending_o), 64'd1);
        chk("ip_act", 64'(active_buf_o), 64'd0);
        fb0_addr_i = 64'h8800_0000;
        tick();
        chk("ip_track", start_addr_o, 64'h8800_0000);
        enable_i = 1'b1;
        tick();
        chk("ip_act1", 64'(active_buf_o), 64'd1);
        chk("ip_done", 64'(swap_done_o), 64'd1);
        chk("ip_pend0", 64'(swap_pending_o), 64'd0);
        chk("ip_addr", start_addr_o, 64'h9000_0000);
        tick();
        tick();
        chk("ip_run", 64'(fetch_enable_o), 64'd1);

        // reset mid-drain with swap pending
        ar_set(1'b1);
        tick();
        ar_set(1'b0);
        swap_req_i = 1'b1;
        tick();
        swap_req_i = 1'b0;
        vsync_i = 1'b1;
        tick();
        vsync_i = 1'b0;
        chk("rd_drain", 64'(fetch_enable_o), 64'd0);
        chk("rd_pend", 64'(swap_pending_o), 64'd1);
        enable_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rd_fetch", 64'(fetch_enable_o), 64'd0);
        chk("rd_act", 64'(active_buf_o), 64'd0);
        chk("rd_pend0", 64'(swap_pending_o), 64'd0);
        chk("rd_done", 64'(swap_done_o), 64'd0);
        chk("rd_busy", 64'(busy_o), 64'd0);
        chk("rd_addr", start_addr_o, 64'd0);
        chk("rd_cnt", 64'(dut.u_burst_cnt.cnt_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("rd_rel_busy", 64'(busy_o), 64'd0);
        chk("rd_rel_done", 64'(swap_done_o), 64'd0);
        chk("rd_rel_addr", start_addr_o, 64'h8800_0000);

        // counter saturation
        ar_set(1'b1);
        repeat (16) tick();
        ar_set(1'b0);
        chk("sat_max", 64'(dut.u_burst_cnt.cnt_o), 64'd15);
        rl_set(1'b1);
        tick();
        rl_set(1'b0);
        chk("sat_dec", 64'(dut.u_burst_cnt.cnt_o), 64'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
